// File: rtl/ibram_pkg.sv
// Shared defaults and FSM encoding for the ping-pong activation input buffer.
package ibram_pkg;
  localparam int NUM_BANKS_DEF = 8;
  localparam int ACT_WIDTH_DEF = 16;
  localparam int ACT_DEPTH_DEF = 512;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    INIT_WRITE = 2'd1,
    WRITE      = 2'd2,
    STALL      = 2'd3
  } ibram_state_e;
endpackage

// File: rtl/ibram_pp_bank.sv
// One bank: 2*ACT_DEPTH simple dual-port RAM split into ping/pong halves,
// plus fill/readout pointers, full flags and committed word counts.
module ibram_pp_bank #(
  parameter int ACT_WIDTH = 16,
  parameter int ACT_DEPTH = 512,
  parameter int AW        = $clog2(ACT_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we_i,
  input  logic [ACT_WIDTH-1:0] wdata_i,
  input  logic                 commit_i,
  input  logic                 rd_en_i,
  input  logic [AW-1:0]        rd_addr_i,
  input  logic                 rd_release_i,
  output logic                 free_o,
  output logic                 nxt_free_o,
  output logic                 ovf_o,
  output logic                 rd_valid_o,
  output logic [AW:0]          rd_len_o,
  output logic [ACT_WIDTH-1:0] rd_data_o
);
  localparam logic [AW:0] CNT_MAX = (AW+1)'(ACT_DEPTH);

  logic                 wr_ptr_q, rd_ptr_q, wr_ptr_d;
  logic [1:0]           full_q, full_d;
  logic [1:0][AW:0]     len_q;
  logic [AW:0]          wr_cnt_q, cnt_nxt;
  logic                 wr_ok, rel;
  logic [ACT_WIDTH-1:0] mem [2*ACT_DEPTH];
  logic [ACT_WIDTH-1:0] rd_data_q;

  assign wr_ok   = we_i && (wr_cnt_q != CNT_MAX);
  assign ovf_o   = we_i && !wr_ok;
  assign cnt_nxt = wr_cnt_q + (AW+1)'(wr_ok);
  assign rel     = rd_release_i && full_q[rd_ptr_q];

  // Commit and release always target different halves, so both may apply.
  always_comb begin
    full_d = full_q;
    if (rel)      full_d[rd_ptr_q] = 1'b0;
    if (commit_i) full_d[wr_ptr_q] = 1'b1;
    wr_ptr_d = wr_ptr_q ^ commit_i;
  end

  assign free_o     = !full_q[wr_ptr_q];
  assign nxt_free_o = !full_d[wr_ptr_d];
  assign rd_valid_o = full_q[rd_ptr_q];
  assign rd_len_o   = rd_valid_o ? len_q[rd_ptr_q] : '0;
  assign rd_data_o  = rd_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      full_q   <= '0;
      len_q    <= '0;
      wr_cnt_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      full_q   <= full_d;
      if (rel) rd_ptr_q <= ~rd_ptr_q;
      if (commit_i) begin
        len_q[wr_ptr_q] <= cnt_nxt;
        wr_cnt_q        <= '0;
      end else begin
        wr_cnt_q <= cnt_nxt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[{wr_ptr_q, wr_cnt_q[AW-1:0]}] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       rd_data_q <= '0;
    else if (rd_en_i) rd_data_q <= mem[{rd_ptr_q, rd_addr_i}];
  end
endmodule

// File: rtl/ibram_pingpong_ctrl.sv
// Ping-pong activation input buffer: fill FSM, source muxing, readiness and error flags.
// Define IBRAM_ERR_STATUS_EN to build the sticky ovf_err/drop_err flags.
module ibram_pingpong_ctrl
  import ibram_pkg::*;
#(
  parameter int NUM_BANKS = NUM_BANKS_DEF,
  parameter int ACT_WIDTH = ACT_WIDTH_DEF,
  parameter int ACT_DEPTH = ACT_DEPTH_DEF,
  localparam int AW       = $clog2(ACT_DEPTH)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic                                 stop,
  input  logic [ACT_WIDTH-1:0]                 di_1,
  input  logic                                 we_1,
  input  logic [NUM_BANKS-1:0]                 bank_sel_1,
  input  logic                                 wr_done_1,
  input  logic [NUM_BANKS-1:0][ACT_WIDTH-1:0]  di_2,
  input  logic [NUM_BANKS-1:0]                 we_2,
  input  logic                                 wr_done_2,
  output logic                                 wr_ready,
  output logic [NUM_BANKS-1:0]                 rd_valid,
  output logic [NUM_BANKS-1:0][AW:0]           rd_len,
  input  logic [NUM_BANKS-1:0]                 rd_en,
  input  logic [NUM_BANKS-1:0][AW-1:0]         rd_addr,
  output logic [NUM_BANKS-1:0][ACT_WIDTH-1:0]  rd_data,
  input  logic [NUM_BANKS-1:0]                 rd_release,
  output logic                                 ovf_err,
  output logic                                 drop_err
);
  ibram_state_e state_q, state_d, pend_q, pend_d, tgt;
  logic stop_q, stop_d, commit, acc1, acc2, nxt_rdy;
  logic [NUM_BANKS-1:0] bank_free, bank_nxt_free, bank_ovf, bank_we;
  logic [NUM_BANKS-1:0][ACT_WIDTH-1:0] bank_wd;

  assign wr_ready = &bank_free;
  assign nxt_rdy  = &bank_nxt_free;
  assign acc1     = (state_q == INIT_WRITE) && wr_ready;
  assign acc2     = (state_q == WRITE) && wr_ready;
  assign commit   = (acc1 && wr_done_1) || (acc2 && wr_done_2);

  // nxt_rdy folds in this cycle's commit/release so STALL is entered/left exactly
  // when wr_ready changes.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    stop_d  = stop_q;
    tgt     = WRITE;
    case (state_q)
      IDLE: begin
        stop_d = 1'b0;
        if (start) state_d = INIT_WRITE;
      end
      INIT_WRITE: if (commit) begin
        pend_d  = WRITE;
        state_d = nxt_rdy ? WRITE : STALL;
      end
      WRITE: begin
        stop_d = stop_q | stop;
        if (commit) begin
          tgt     = (stop_q | stop) ? IDLE : WRITE;
          pend_d  = tgt;
          state_d = nxt_rdy ? tgt : STALL;
        end
      end
      STALL: if (nxt_rdy) state_d = pend_q;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q  <= WRITE;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      stop_q  <= stop_d;
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    assign bank_we[b] = acc1 ? (we_1 & bank_sel_1[b]) : (acc2 & we_2[b]);
    assign bank_wd[b] = acc1 ? di_1 : di_2[b];

    ibram_pp_bank #(.ACT_WIDTH(ACT_WIDTH), .ACT_DEPTH(ACT_DEPTH), .AW(AW)) u_bank (
      .clk          (clk),
      .rst_n        (rst_n),
      .we_i         (bank_we[b]),
      .wdata_i      (bank_wd[b]),
      .commit_i     (commit),
      .rd_en_i      (rd_en[b]),
      .rd_addr_i    (rd_addr[b]),
      .rd_release_i (rd_release[b]),
      .free_o       (bank_free[b]),
      .nxt_free_o   (bank_nxt_free[b]),
      .ovf_o        (bank_ovf[b]),
      .rd_valid_o   (rd_valid[b]),
      .rd_len_o     (rd_len[b]),
      .rd_data_o    (rd_data[b])
    );
  end

`ifdef IBRAM_ERR_STATUS_EN
  logic ovf_q, drop_q, drop_pulse;
  assign drop_pulse = (we_1 && !acc1) || ((|we_2) && !acc2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q  <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      ovf_q  <= ovf_q | (|bank_ovf);
      drop_q <= drop_q | drop_pulse;
    end
  end

  assign ovf_err  = ovf_q;
  assign drop_err = drop_q;
`else
  logic unused_err;
  assign unused_err = ^bank_ovf;
  assign ovf_err    = 1'b0;
  assign drop_err   = 1'b0;
`endif
endmodule

// File: tb/tb_ibram_pingpong_ctrl.sv
// Directed bench for ibram_pingpong_ctrl with a read-data scoreboard.
module tb_ibram_pingpong_ctrl;
  localparam int NB = 8, W = 16, D = 512, AW = 9;
`ifdef IBRAM_ERR_STATUS_EN
  localparam logic ERR = 1'b1;
`else
  localparam logic ERR = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic start, stop, we_1, wr_done_1, wr_done_2, wr_ready, ovf_err, drop_err;
  logic [W-1:0] di_1;
  logic [NB-1:0] bank_sel_1, we_2, rd_valid, rd_en, rd_release;
  logic [NB-1:0][W-1:0] di_2, rd_data;
  logic [NB-1:0][AW:0] rd_len;
  logic [NB-1:0][AW-1:0] rd_addr;

  int n_vec = 0, n_bad = 0;
  typedef struct { int b; logic [W-1:0] d; } rd_exp_t;
  rd_exp_t sb[$];

  ibram_pingpong_ctrl #(.NUM_BANKS(NB), .ACT_WIDTH(W), .ACT_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .di_1(di_1), .we_1(we_1), .bank_sel_1(bank_sel_1), .wr_done_1(wr_done_1),
    .di_2(di_2), .we_2(we_2), .wr_done_2(wr_done_2), .wr_ready(wr_ready),
    .rd_valid(rd_valid), .rd_len(rd_len), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_release(rd_release), .ovf_err(ovf_err), .drop_err(drop_err)
  );

  task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic clr();
    start = 0; stop = 0; we_1 = 0; wr_done_1 = 0; wr_done_2 = 0;
    we_2 = '0; rd_en = '0; rd_release = '0;
  endtask

  // Advance one clock, score reads issued before the edge, drop all pulses.
  task automatic tick();
    rd_exp_t e;
    @(posedge clk); #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk($sformatf("rdata_b%0d", e.b), rd_data[e.b], e.d);
    end
    clr();
  endtask

  task automatic rd_bank(int b, int a, logic [W-1:0] e);
    rd_en[b] = 1'b1;
    rd_addr[b] = AW'(a);
    sb.push_back('{b, e});
  endtask

  task automatic chk_len(string tag, int b, int e);
    chk(tag, 32'(rd_len[b]), e);
  endtask

  initial begin
    clr(); di_1 = '0; bank_sel_1 = '0; di_2 = '0; rd_addr = '0;
    #2;
    chk("rst_ready", wr_ready, 1); chk("rst_valid", rd_valid, 0);
    chk("rst_len", |rd_len, 0); chk("rst_rdata", |rd_data, 0);
    chk("rst_ovf", ovf_err, 0); chk("rst_drop", drop_err, 0);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // Init stream broadcast to banks 0 and 2
    start = 1; tick();
    for (int i = 0; i < 5; i++) begin
      we_1 = 1; bank_sel_1 = 8'b0000_0101; di_1 = W'(16'hA000 + i); tick();
    end
    wr_done_1 = 1; tick();
    chk("init_valid", rd_valid, 8'hFF); chk_len("init_len0", 0, 5);
    chk_len("init_len2", 2, 5); chk_len("init_len1", 1, 0); chk_len("init_len7", 7, 0);
    chk("init_ready", wr_ready, 1);
    for (int a = 0; a < 5; a++) begin
      rd_bank(0, a, W'(16'hA000 + a)); rd_bank(2, a, W'(16'hA000 + a)); tick();
    end

    // Parallel fill; last strobe coincides with wr_done_2
    for (int i = 0; i < 3; i++) begin
      we_2 = '1;
      for (int b = 0; b < NB; b++) di_2[b] = W'(b * 4096 + 256 + i);
      if (i == 2) wr_done_2 = 1;
      tick();
    end
    chk("stall_ready", wr_ready, 0); chk("stall_valid", rd_valid, 8'hFF);
    chk_len("stall_len0", 0, 5); chk_len("stall_len5", 5, 0);
    chk("pre_drop", drop_err, 0);
    we_2 = '1; for (int b = 0; b < NB; b++) di_2[b] = 16'hDEAD; tick();
    chk("drop_set", drop_err, ERR); chk("ovf_clear", ovf_err, 0);

    rd_release = '1; tick();
    chk("rel_ready", wr_ready, 1); chk("rel_valid", rd_valid, 8'hFF);
    for (int b = 0; b < NB; b++) chk_len($sformatf("rel_len%0d", b), b, 3);
    for (int a = 0; a < 3; a++) begin
      for (int b = 0; b < NB; b++) rd_bank(b, a, W'(b * 4096 + 256 + a));
      tick();
    end

    // Overflow: 513 writes into a 512-word half
    for (int i = 0; i < 513; i++) begin
      we_2 = 8'h01; di_2[0] = (i < 512) ? W'(16'h5000 + i) : 16'hFFFF; tick();
    end
    chk("ovf_set", ovf_err, ERR);
    wr_done_2 = 1; tick();
    chk("ovf_ready", wr_ready, 0); chk_len("ovf_len_old", 0, 3);
    rd_release = 8'h01; tick();
    chk_len("ovf_len512", 0, 512); chk("ovf_valid", rd_valid, 8'hFF);
    chk("ovf_ready2", wr_ready, 0);
    rd_bank(0, 511, 16'h51FF); tick();
    rd_bank(0, 0, 16'h5000); tick();
    rd_release = 8'hFE; tick();
    chk("unstall_ready", wr_ready, 1); chk_len("unstall_len0", 0, 512);
    chk_len("unstall_len3", 3, 0);

    // Bank 3: commit and release in the same cycle
    for (int i = 0; i < 3; i++) begin
      we_2 = 8'h08; di_2[3] = W'(16'h3300 + i);
      if (i == 2) begin wr_done_2 = 1; rd_release = 8'h08; end
      tick();
    end
    chk("cr_valid", rd_valid, 8'hFF); chk_len("cr_len3", 3, 3);
    chk_len("cr_len0", 0, 512); chk_len("cr_len1", 1, 0); chk("cr_ready", wr_ready, 0);
    for (int a = 0; a < 3; a++) begin rd_bank(3, a, W'(16'h3300 + a)); tick(); end

    // Latched stop: empty commit then back to IDLE once drained
    rd_release = 8'hF7; tick();
    chk("stop_ready0", wr_ready, 1);
    stop = 1; tick();
    tick();
    wr_done_2 = 1; tick();
    chk("stop_ready1", wr_ready, 0);
    rd_release = '1; tick();
    chk("stop_ready2", wr_ready, 1); chk_len("stop_len0", 0, 0);
    start = 1; tick();
    for (int i = 0; i < 2; i++) begin
      we_1 = 1; bank_sel_1 = 8'h02; di_1 = W'(16'hB000 + i); tick();
    end
    wr_done_1 = 1; tick();
    chk_len("reinit_len_old", 1, 0); chk("reinit_ready", wr_ready, 0);
    rd_release = '1; tick();
    chk_len("reinit_len1", 1, 2); chk("reinit_ready2", wr_ready, 1);
    for (int a = 0; a < 2; a++) begin rd_bank(1, a, W'(16'hB000 + a)); tick(); end

    // Asynchronous reset mid-WRITE
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ready", wr_ready, 1); chk("arst_valid", rd_valid, 0);
    chk("arst_len", |rd_len, 0); chk("arst_rdata", |rd_data, 0);
    chk("arst_ovf", ovf_err, 0); chk("arst_drop", drop_err, 0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    start = 1; tick();
    we_1 = 1; bank_sel_1 = 8'h80; di_1 = 16'hC0DE; tick();
    wr_done_1 = 1; tick();
    chk("post_valid", rd_valid, 8'hFF); chk_len("post_len7", 7, 1);
    chk("post_drop", drop_err, 0);
    rd_bank(7, 0, 16'hC0DE); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
